// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   uart_tx_state_t      - transmit FSM state encoding
//   DATA_BITS            - data bits per frame
//   BITS_PER_CLK_DEFAULT - default clocks per serial bit (50 MHz / 9600 baud)
//   parityBit()          - parity of a data byte, optionally inverted for odd
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int BITS_PER_CLK_DEFAULT = 5208;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   // Even parity is the XOR of all data bits; odd parity is its inverse.
   function automatic logic parityBit(input logic [DATA_BITS-1:0] dataByte,
                                      input logic                 oddSel);
      return (^dataByte) ^ oddSel;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Single-clock synchronous FIFO holding bytes waiting to be transmitted.
// Pointers wrap naturally (DEPTH is a power of two); occupancy and the
// full/empty flags are registered and change on the write/pop edge.
// Ports:
//   clk, rst (async, active low)
//   wr_en, wr_data  - push request; ignored while full
//   rd_en, rd_data  - pop request; rd_data shows the head combinationally
//   level           - occupancy 0..DEPTH
//   full, empty     - registered occupancy flags
// ---------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = DATA_BITS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      full,
   output logic                      empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wrPtr_r;
   logic [PTR_W-1:0] rdPtr_r;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] levelNext_s;
   logic             full_r;
   logic             empty_r;
   logic             push_s;
   logic             pop_s;

   // Qualify requests with the registered flags and derive next occupancy.
   always_comb begin
      push_s = wr_en & ~full_r;
      pop_s  = rd_en & ~empty_r;
      if (push_s && !pop_s) begin
         levelNext_s = level_r + LVL_W'(1);
      end else if (pop_s && !push_s) begin
         levelNext_s = level_r - LVL_W'(1);
      end else begin
         levelNext_s = level_r;
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wrPtr_r] <= wr_data;
      end
   end

   // Pointers, occupancy and flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_r <= {PTR_W{1'b0}};
         rdPtr_r <= {PTR_W{1'b0}};
         level_r <= {LVL_W{1'b0}};
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         if (push_s) begin
            wrPtr_r <= wrPtr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rdPtr_r <= rdPtr_r + PTR_W'(1);
         end
         level_r <= levelNext_s;
         full_r  <= (levelNext_s == LVL_W'(DEPTH));
         empty_r <= (levelNext_s == {LVL_W{1'b0}});
      end
   end

   assign rd_data = mem_r[rdPtr_r];
   assign level   = level_r;
   assign full    = full_r;
   assign empty   = empty_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter. Bytes written on the parallel side are queued
// in uart_tx_fifo and sent as frames: start (0), 8 data bits LSB first,
// optional parity, stop (1). Back-to-back frames follow without idle bits.
// Ports:
//   clk, rst (async, active low)
//   wr_en, wr_data    - queue a byte; wr_data[7] is the LSB (sent first)
//   full, empty, level- FIFO status (registered)
//   overflow          - one-cycle pulse after a write was dropped while full
//   serialData        - registered serial line, idles high
//   busy              - a frame is in progress
//   doneTx            - one-cycle pulse after each stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int bitsPerClk = BITS_PER_CLK_DEFAULT,
   parameter int FIFO_DEPTH = 8,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [0:7]                    wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          serialData,
   output logic                          busy,
   output logic                          doneTx
);

   localparam int                CNT_W     = $clog2(bitsPerClk);
   localparam int                IDX_W     = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(bitsPerClk - 1);
   localparam logic [IDX_W-1:0]  BIT_LAST  = IDX_W'(DATA_BITS - 1);

   uart_tx_state_t                state_r;
   uart_tx_state_t                nextState_s;
   logic [CNT_W-1:0]              baudCnt_r;
   logic [CNT_W-1:0]              baudNext_s;
   logic [IDX_W-1:0]              bitIdx_r;
   logic [IDX_W-1:0]              bitIdxNext_s;
   logic [DATA_BITS-1:0]          shiftReg_r;
   logic [DATA_BITS-1:0]          shiftNext_s;
   logic                          parity_r;
   logic                          parityNext_s;
   logic                          serial_r;
   logic                          serialNext_s;
   logic                          busy_r;
   logic                          done_r;
   logic                          doneNext_s;
   logic                          overflow_r;
   logic                          bitEnd_s;
   logic                          pop_s;
   logic [DATA_BITS-1:0]          txByte_s;
   logic [DATA_BITS-1:0]          fifoData_s;
   logic [$clog2(FIFO_DEPTH):0]   fifoLevel_s;
   logic                          fifoFull_s;
   logic                          fifoEmpty_s;

   // The input port is numbered MSB-first (index 7 = LSB); a plain assignment
   // to a descending vector keeps the byte value, so bit 0 is the LSB here.
   assign txByte_s = wr_data;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (txByte_s),
      .rd_en   (pop_s),
      .rd_data (fifoData_s),
      .level   (fifoLevel_s),
      .full    (fifoFull_s),
      .empty   (fifoEmpty_s)
   );

   // Next-state logic for the frame sequencer.
   always_comb begin
      bitEnd_s    = (baudCnt_r == BAUD_LAST);
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (!fifoEmpty_s) begin
               nextState_s = START;
            end else begin
               nextState_s = IDLE;
            end
         end
         START: begin
            if (bitEnd_s) begin
               nextState_s = DATA;
            end else begin
               nextState_s = START;
            end
         end
         DATA: begin
            if (bitEnd_s && (bitIdx_r == BIT_LAST)) begin
               if (PARITY_EN) begin
                  nextState_s = PARITY;
               end else begin
                  nextState_s = STOP;
               end
            end else begin
               nextState_s = DATA;
            end
         end
         PARITY: begin
            if (bitEnd_s) begin
               nextState_s = STOP;
            end else begin
               nextState_s = PARITY;
            end
         end
         STOP: begin
            // A queued byte chains straight into the next start bit.
            if (bitEnd_s) begin
               if (!fifoEmpty_s) begin
                  nextState_s = START;
               end else begin
                  nextState_s = IDLE;
               end
            end else begin
               nextState_s = STOP;
            end
         end
         default: nextState_s = IDLE;
      endcase
   end

   // Datapath and output next-values: serialData carries the value of the
   // state (or data bit) being entered on the same edge.
   always_comb begin
      pop_s        = 1'b0;
      serialNext_s = serial_r;
      shiftNext_s  = shiftReg_r;
      bitIdxNext_s = bitIdx_r;
      parityNext_s = parity_r;
      doneNext_s   = 1'b0;
      if ((state_r == IDLE) || bitEnd_s) begin
         baudNext_s = {CNT_W{1'b0}};
      end else begin
         baudNext_s = baudCnt_r + CNT_W'(1);
      end
      case (state_r)
         IDLE: begin
            if (!fifoEmpty_s) begin
               pop_s        = 1'b1;
               shiftNext_s  = fifoData_s;
               parityNext_s = parityBit(fifoData_s, PARITY_ODD);
               bitIdxNext_s = {IDX_W{1'b0}};
               serialNext_s = 1'b0;
            end else begin
               serialNext_s = 1'b1;
            end
         end
         START: begin
            if (bitEnd_s) begin
               serialNext_s = shiftReg_r[0];
               shiftNext_s  = {1'b0, shiftReg_r[DATA_BITS-1:1]};
               bitIdxNext_s = {IDX_W{1'b0}};
            end else begin
               serialNext_s = serial_r;
            end
         end
         DATA: begin
            if (bitEnd_s && (bitIdx_r == BIT_LAST)) begin
               if (PARITY_EN) begin
                  serialNext_s = parity_r;
               end else begin
                  serialNext_s = 1'b1;
               end
            end else if (bitEnd_s) begin
               serialNext_s = shiftReg_r[0];
               shiftNext_s  = {1'b0, shiftReg_r[DATA_BITS-1:1]};
               bitIdxNext_s = bitIdx_r + IDX_W'(1);
            end else begin
               serialNext_s = serial_r;
            end
         end
         PARITY: begin
            if (bitEnd_s) begin
               serialNext_s = 1'b1;
            end else begin
               serialNext_s = serial_r;
            end
         end
         STOP: begin
            if (bitEnd_s) begin
               doneNext_s = 1'b1;
               if (!fifoEmpty_s) begin
                  pop_s        = 1'b1;
                  shiftNext_s  = fifoData_s;
                  parityNext_s = parityBit(fifoData_s, PARITY_ODD);
                  bitIdxNext_s = {IDX_W{1'b0}};
                  serialNext_s = 1'b0;
               end else begin
                  serialNext_s = 1'b1;
               end
            end else begin
               serialNext_s = serial_r;
            end
         end
         default: serialNext_s = 1'b1;
      endcase
   end

   // State register plus registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         baudCnt_r  <= {CNT_W{1'b0}};
         bitIdx_r   <= {IDX_W{1'b0}};
         shiftReg_r <= {DATA_BITS{1'b0}};
         parity_r   <= 1'b0;
         serial_r   <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         state_r    <= nextState_s;
         baudCnt_r  <= baudNext_s;
         bitIdx_r   <= bitIdxNext_s;
         shiftReg_r <= shiftNext_s;
         parity_r   <= parityNext_s;
         serial_r   <= serialNext_s;
         busy_r     <= (nextState_s != IDLE);
         done_r     <= doneNext_s;
         // Uses the registered full flag, so a same-cycle pop does not save the byte.
         overflow_r <= wr_en & fifoFull_s;
      end
   end

   assign full       = fifoFull_s;
   assign empty      = fifoEmpty_s;
   assign level      = fifoLevel_s;
   assign overflow   = overflow_r;
   assign serialData = serial_r;
   assign busy       = busy_r;
   assign doneTx     = done_r;

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes from the parallel side into an internal FIFO and serialises them as 8-data-bit frames with optional parity and one stop bit. It is the transmit-side counterpart to the existing UART receiver. Its frame format (start, data LSB first, parity, stop) matches what that receiver checks, so one instance drives the receiver's serial input directly. Firmware can queue bursts of bytes without waiting on per-byte done handshakes.

## Interface
- bitsPerClk, 5208: clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 2
- FIFO_DEPTH, 8: FIFO entries; power of two, ≥ 2
- PARITY_EN, 1: 1 = parity bit inserted after data bits, 0 = no parity bit
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  push wr_data into FIFO this cycle
- wr_data  input  [0:7]  byte to send; index 7 is the LSB
- full  output  1  FIFO holds FIFO_DEPTH entries
- empty  output  1  FIFO holds no entries
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  one-cycle pulse: a write was dropped
- serialData  output  1  serial line; idles high
- busy  output  1  a frame is in progress (state ≠ IDLE)
- doneTx  output  1  one-cycle pulse at completion of each stop bit

## Operation
- **Frame format:**
  - Start bit is 0.
  - Data bits follow in the order wr_data[7], [6], …, [0].
  - When PARITY_EN = 1, a parity bit follows the data: XOR of the data bits, inverted when PARITY_ODD = 1.
  - Stop bit is 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when level ≠ 0. The FIFO head is popped into the shift register the same edge.
  - START → DATA after bitsPerClk cycles.
  - DATA holds for 8 bit periods; a bit index runs 0..7.
  - DATA → PARITY (PARITY_EN = 1) or → STOP (PARITY_EN = 0).
  - PARITY → STOP.
  - At the end of STOP, doneTx pulses. If level ≠ 0, the next byte is popped and the FSM goes straight to START with no idle bit. Otherwise it goes to IDLE.
- **Baud counter:** counts 0..bitsPerClk−1 and resets to 0 on every state transition. The bit ends when the counter reaches bitsPerClk−1.
- **serialData** is registered. Its value for each state is driven from the edge that enters that state.
- **FIFO write:** wr_en with full = 0 stores wr_data at the tail.
  - wr_en with full = 1 drops the byte and pulses overflow the next cycle. This holds even if a pop occurs the same cycle; full is the registered value.
- **Simultaneous write and pop:** level is unchanged and both operations take effect.
- **Pointer width:** read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- **Reset values:**
  - serialData = 1
  - busy = 0, doneTx = 0, overflow = 0
  - full = 0, empty = 1, level = 0
  - FSM = IDLE, FIFO pointers = 0
- **Reset mid-frame:** serialData returns high asynchronously, the FIFO contents are discarded, and no doneTx is issued.
- **Write to start latency:**
  - A write on edge E into an empty, idle block makes level = 1 after E.
  - On edge E+1 the byte is popped, START is entered, and serialData goes to 0.
- **Frame length:** (10 + PARITY_EN) × bitsPerClk cycles.
- **doneTx:** high for exactly the one cycle following the last stop-bit cycle.
- **busy:** high from the START entry edge until the edge that returns the FSM to IDLE.
- **full / empty / level:** registered and updated on the same edge as the write or pop.

## Structure
- **Package uart_pkg holds:**
  - the FSM state enum (uart_tx_state_t)
  - DATA_BITS = 8
  - the default bitsPerClk value
  - a parity helper function
- **Sub-module uart_tx_fifo:** synchronous single-clock FIFO with wr_en/wr_data/rd_en/rd_data/level/full/empty and registered flags, parameterised by depth. The FSM and baud counter live in the top module.

## Test plan
Directed tests use bitsPerClk = 4, FIFO_DEPTH = 8, PARITY_EN = 1, PARITY_ODD = 0 unless stated.
1. **Reset:** assert rst low mid-run → all outputs at the reset values listed in Timing, serialData = 1.
2. **Single byte:** one write of 8'hA5 → serialData holds 0,1,0,1,0,0,1,0,1,0,1 for 4 cycles each (start, data bits, parity 0, stop). Total 44 cycles, doneTx pulses once at cycle 45, busy drops the same edge.
3. **Back-to-back:** write 8'h01, 8'h80, 8'hFF on consecutive cycles → three frames with no idle bit between them, 132 cycles total, doneTx pulses 44 cycles apart, empty after the first pop of the third byte.
4. **Overflow:** write 10 bytes on 10 consecutive cycles → 9 accepted (first popped after one cycle), full after the 9th write edge, 10th dropped with one overflow pulse, 9 frames transmitted in order.
5. **Odd parity:** PARITY_ODD = 1, PARITY_EN = 1, send 8'h00 → parity bit = 1. With PARITY_EN = 0 → 40-cycle frame with no parity bit.
6. **Reset mid-frame:** pull rst low during the DATA state of the second of two queued bytes → serialData high immediately, level = 0, no doneTx. After release the line stays idle.
